// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scoreboard: forward-select codes and
// the multi-cycle unit state enumeration.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments on inc and holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every combinational output gets a default on entry so no path
    // leaves it unassigned and a latch is never inferred.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: E-stage forwarding, load-use and scoreboard stalls,
// PC-write flushes, a single-issue multi-cycle unit tracker and event counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    input  logic [ADDR_W-1:0] RA1E,
    input  logic [ADDR_W-1:0] RA2E,
    input  logic [ADDR_W-1:0] WA3E,
    input  logic [ADDR_W-1:0] WA3M,
    input  logic [ADDR_W-1:0] WA3W,
    input  logic [ADDR_W-1:0] WA3D,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              BranchTakenE,
    input  logic              PCSrcD,
    input  logic              PCSrcE,
    input  logic              PCSrcM,
    input  logic              PCSrcW,
    input  logic              MulOpD,
    input  logic              MulStartE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              MulBusy,
    output logic              MulDone,
    output logic [ADDR_W-1:0] MulDst,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    localparam int                NREGS   = 2 ** ADDR_W;
    localparam int                LAT_W   = $clog2(MUL_LAT + 1);
    localparam logic [ADDR_W-1:0] PC_ADDR = '1;

    mul_state_e        state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [NREGS-1:0]  pending_q, pending_d;

    logic mul_busy, mul_done;
    logic ldr_stall, sb_stall, pc_wr_pending;

    // The PC is written outside the normal writeback path, so it is never a bypass source.
    function automatic fwd_sel_e fwd_select(
        input logic [ADDR_W-1:0] src,
        input logic              rw_m,
        input logic [ADDR_W-1:0] wa_m,
        input logic              rw_w,
        input logic [ADDR_W-1:0] wa_w
    );
        if (src == PC_ADDR)           return FWD_RF;
        if (rw_m && (wa_m == src))    return FWD_MEM;
        if (rw_w && (wa_w == src))    return FWD_WB;
        return FWD_RF;
    endfunction

    // Multi-cycle unit: state register.
    // NOTE: the pending vector is reset explicitly; a stale bit left over
    // from an aborted op would stall decode on that register forever.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MUL_IDLE;
            cnt_q     <= '0;
            dst_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dst_q     <= dst_d;
            pending_q <= pending_d;
        end
    end

    // Multi-cycle unit: next state. Starts while BUSY are dropped, which keeps
    // at most one pending bit live.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dst_d     = dst_q;
        pending_d = pending_q;
        case (state_q)
            MUL_IDLE: begin
                if (MulStartE) begin
                    state_d         = MUL_BUSY;
                    cnt_d           = LAT_W'(MUL_LAT);
                    dst_d           = WA3E;
                    pending_d       = '0;
                    pending_d[WA3E] = 1'b1;
                end
            end
            MUL_BUSY: begin
                if (cnt_q == LAT_W'(1)) begin
                    state_d          = MUL_IDLE;
                    pending_d[dst_q] = 1'b0;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // Multi-cycle unit: outputs.
    always_comb begin
        mul_busy = (state_q == MUL_BUSY);
        mul_done = (state_q == MUL_BUSY) && (cnt_q == LAT_W'(1));
    end

    // Hazard detection; reset forces the pipeline into a flushed, unstalled state.
    always_comb begin
        ldr_stall     = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
        sb_stall      = pending_q[RA1D] || pending_q[RA2D] || pending_q[WA3D]
                        || (MulOpD && mul_busy);
        pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;

        ForwardAE = fwd_select(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
        ForwardBE = fwd_select(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
        StallF    = ldr_stall || sb_stall || pc_wr_pending;
        StallD    = ldr_stall || sb_stall;
        FlushD    = pc_wr_pending || PCSrcW || BranchTakenE;
        FlushE    = ldr_stall || sb_stall || BranchTakenE;
        MulBusy   = mul_busy;
        MulDone   = mul_done;
        MulDst    = dst_q;

        if (reset) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            StallF    = 1'b0;
            StallD    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            MulBusy   = 1'b0;
            MulDone   = 1'b0;
            MulDst    = '0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallD),
        .count (StallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (FlushE),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Random and directed stimulus for hazard_scoreboard, checked every cycle
// against a cycle-numbered behavioural model of the hazard rules.
module tb_hazard_scoreboard;

    localparam int ADDR_W  = 4;
    localparam int MUL_LAT = 3;
    localparam int CNT_W   = 5;     // narrow so saturation is reached in a short run
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int PC      = (1 << ADDR_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic [ADDR_W-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, WA3D;
    logic RegWriteM, RegWriteW, MemtoRegE, BranchTakenE;
    logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, MulOpD, MulStartE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, FlushD, FlushE, MulBusy, MulDone;
    logic [ADDR_W-1:0] MulDst;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycle numbers of the one tracked multi-cycle op.
    int  cyc      = 0;
    bit  m_active = 0;
    int  m_start  = 0;
    int  m_dst    = 0;
    int  m_stalls = 0;
    int  m_flushes = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .ADDR_W (ADDR_W),
        .MUL_LAT(MUL_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .RA1D        (RA1D),
        .RA2D        (RA2D),
        .RA1E        (RA1E),
        .RA2E        (RA2E),
        .WA3E        (WA3E),
        .WA3M        (WA3M),
        .WA3W        (WA3W),
        .WA3D        (WA3D),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .MemtoRegE   (MemtoRegE),
        .BranchTakenE(BranchTakenE),
        .PCSrcD      (PCSrcD),
        .PCSrcE      (PCSrcE),
        .PCSrcM      (PCSrcM),
        .PCSrcW      (PCSrcW),
        .MulOpD      (MulOpD),
        .MulStartE   (MulStartE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .MulBusy     (MulBusy),
        .MulDone     (MulDone),
        .MulDst      (MulDst),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int exp_fwd(input int src);
        if (src == PC)                      return 0;
        if (RegWriteM && int'(WA3M) == src) return 2;
        if (RegWriteW && int'(WA3W) == src) return 1;
        return 0;
    endfunction

    // A multi-cycle op started in cycle s occupies cycles s+1 .. s+MUL_LAT.
    function automatic bit m_busy();
        return m_active && (cyc > m_start) && (cyc <= m_start + MUL_LAT);
    endfunction

    function automatic bit m_pend(input int a);
        return m_busy() && (a == m_dst);
    endfunction

    task automatic clear_inputs();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, WA3D} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, BranchTakenE} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, MulOpD, MulStartE} = '0;
        reset = 1'b0;
        // Keep D/E sources off register 0 unless a test sets them.
        RA1D = 4'd9; RA2D = 4'd10; WA3D = 4'd11; WA3E = 4'd12;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return ADDR_W'(PC);
        return ADDR_W'($urandom_range(0, 6));
    endfunction

    task automatic rand_inputs();
        RA1D = rand_addr(); RA2D = rand_addr(); RA1E = rand_addr(); RA2E = rand_addr();
        WA3E = rand_addr(); WA3M = rand_addr(); WA3W = rand_addr(); WA3D = rand_addr();
        RegWriteM    = ($urandom_range(0, 1) == 1);
        RegWriteW    = ($urandom_range(0, 1) == 1);
        MemtoRegE    = ($urandom_range(0, 3) == 0);
        BranchTakenE = ($urandom_range(0, 7) == 0);
        PCSrcD       = ($urandom_range(0, 7) == 0);
        PCSrcE       = ($urandom_range(0, 7) == 0);
        PCSrcM       = ($urandom_range(0, 7) == 0);
        PCSrcW       = ($urandom_range(0, 7) == 0);
        MulOpD       = ($urandom_range(0, 3) == 0);
        MulStartE    = ($urandom_range(0, 4) == 0);
        reset        = ($urandom_range(0, 49) == 0);
    endtask

    // Called just after a falling edge with inputs applied: checks every
    // output against the model, then advances model and DUT by one clock.
    task automatic step();
        bit busy, done, ldr, sb, pcw;
        bit e_stall_f, e_stall_d, e_flush_d, e_flush_e;
        int e_fa, e_fb;
        #1;
        busy = m_busy();
        done = busy && (cyc == m_start + MUL_LAT);
        ldr  = MemtoRegE && (WA3E == RA1D || WA3E == RA2D);
        sb   = m_pend(int'(RA1D)) || m_pend(int'(RA2D)) || m_pend(int'(WA3D)) || (MulOpD && busy);
        pcw  = PCSrcD || PCSrcE || PCSrcM;
        if (reset) begin
            e_fa = 0; e_fb = 0;
            e_stall_f = 0; e_stall_d = 0; e_flush_d = 1; e_flush_e = 1;
            busy = 0; done = 0;
        end else begin
            e_fa = exp_fwd(int'(RA1E));
            e_fb = exp_fwd(int'(RA2E));
            e_stall_f = ldr || sb || pcw;
            e_stall_d = ldr || sb;
            e_flush_d = pcw || PCSrcW || BranchTakenE;
            e_flush_e = ldr || sb || BranchTakenE;
        end
        check("ForwardAE", ForwardAE, e_fa);
        check("ForwardBE", ForwardBE, e_fb);
        check("StallF", StallF, e_stall_f);
        check("StallD", StallD, e_stall_d);
        check("FlushD", FlushD, e_flush_d);
        check("FlushE", FlushE, e_flush_e);
        check("MulBusy", MulBusy, busy);
        check("MulDone", MulDone, done);
        if (reset)      check("MulDst_reset", MulDst, 0);
        else if (done)  check("MulDst", MulDst, m_dst);
        check("StallCount", StallCount, m_stalls);
        check("FlushCount", FlushCount, m_flushes);

        @(posedge clk);
        if (reset) begin
            m_active  = 0;
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            if (e_stall_d) m_stalls  = (m_stalls  == CNT_MAX) ? CNT_MAX : m_stalls + 1;
            if (e_flush_e) m_flushes = (m_flushes == CNT_MAX) ? CNT_MAX : m_flushes + 1;
            if (MulStartE && !busy) begin
                m_active = 1;
                m_start  = cyc;
                m_dst    = int'(WA3E);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        step();
        step();

        // Forwarding priority and PC exclusion.
        clear_inputs();
        RegWriteM = 1; WA3M = 4'd3; RegWriteW = 1; WA3W = 4'd3; RA1E = 4'd3;
        step();
        RegWriteM = 0;
        step();
        RA1E = 4'd15; RegWriteM = 1; WA3M = 4'd15; WA3W = 4'd15;
        step();

        // Load-use stall for one cycle.
        clear_inputs();
        MemtoRegE = 1; WA3E = 4'd5; RA2D = 4'd5;
        step();
        clear_inputs();
        step();

        // Multi-cycle op on r7 with the decode source held on r7.
        clear_inputs();
        MulStartE = 1; WA3E = 4'd7; RA1D = 4'd7;
        step();
        MulStartE = 0;
        repeat (MUL_LAT + 2) step();

        // MulOpD while busy, plus an ignored second start.
        clear_inputs();
        MulStartE = 1; WA3E = 4'd2;
        step();
        MulStartE = 0; MulOpD = 1;
        step();
        MulStartE = 1; WA3E = 4'd4;
        step();
        MulStartE = 0;
        repeat (MUL_LAT + 2) step();

        // PC write in decode, then a taken branch.
        clear_inputs();
        PCSrcD = 1;
        step();
        clear_inputs();
        BranchTakenE = 1;
        step();
        clear_inputs();
        step();

        // Reset one cycle into a multi-cycle op aborts it.
        clear_inputs();
        MulStartE = 1; WA3E = 4'd6; RA2D = 4'd6;
        step();
        MulStartE = 0; reset = 1;
        step();
        reset = 0;
        repeat (MUL_LAT + 1) step();

        repeat (2000) begin
            rand_inputs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter: ADDR_W, 4, register address width; the register file has 2**ADDR_W entries.
REQ-002 Parameter: MUL_LAT, 3, multi-cycle unit latency in cycles, legal range 2..15.
REQ-003 Parameter: CNT_W, 16, performance counter width.
REQ-004 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Ports: RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W, WA3D  in  ADDR_W each  decode/execute/memory/writeback register addresses.
REQ-007 Ports: RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCSrcD, PCSrcE, PCSrcM, PCSrcW  in  1 each  pipeline control taps.
REQ-008 Ports: MulOpD  in  1  decode instruction targets the multi-cycle unit; MulStartE  in  1  multi-cycle op issuing from E this cycle.
REQ-009 Ports: ForwardAE, ForwardBE  out  2 each  00 register file, 01 writeback result, 10 memory-stage ALU result.
REQ-010 Ports: StallF, StallD, FlushD, FlushE  out  1 each  pipeline control.
REQ-011 Ports: MulBusy  out  1; MulDone  out  1  one-cycle completion pulse; MulDst  out  ADDR_W  destination, valid with MulDone.
REQ-012 Ports: StallCount, FlushCount  out  CNT_W each  saturating event counters.

Function
REQ-013 Forwarding SHALL be combinational: 10 when RegWriteM and WA3M equals the E source; otherwise 01 when RegWriteW and WA3W equals the E source; otherwise 00; M has priority.
REQ-014 Address 2**ADDR_W-1 (PC) SHALL never be forwarded.
REQ-015 LDRstall SHALL be MemtoRegE and WA3E equal to RA1D or RA2D.
REQ-016 SBstall SHALL be pending[RA1D], pending[RA2D] or pending[WA3D] set, or MulOpD while MulBusy.
REQ-017 PCWrPending SHALL be PCSrcD or PCSrcE or PCSrcM.
REQ-018 StallF SHALL be LDRstall, SBstall or PCWrPending; StallD SHALL be LDRstall or SBstall.
REQ-019 FlushD SHALL be PCWrPending, PCSrcW or BranchTakenE; FlushE SHALL be LDRstall, SBstall or BranchTakenE.
REQ-020 The multi-cycle unit SHALL have states IDLE and BUSY; IDLE->BUSY on MulStartE, loading the down-counter with MUL_LAT and latching WA3E as destination.
REQ-021 MulStartE in cycle t SHALL give MulBusy=1 in cycles t+1..t+MUL_LAT, MulDone=1 only in cycle t+MUL_LAT, and BUSY->IDLE at the end of cycle t+MUL_LAT.
REQ-022 pending[WA3E] SHALL set at the edge ending cycle t; pending[MulDst] SHALL clear at the edge ending cycle t+MUL_LAT, so decode stalls release in cycle t+MUL_LAT+1.
REQ-023 The scoreboard SHALL hold at most one pending bit; MulStartE while BUSY is illegal and SHALL be ignored.
REQ-024 StallCount SHALL increment in each cycle with StallD=1; FlushCount SHALL increment in each cycle with FlushE=1; both saturate at all-ones.

Reset
REQ-025 While reset=1: StallF=StallD=0, FlushD=FlushE=1, ForwardAE=ForwardBE=00, MulBusy=MulDone=0, MulDst=0.
REQ-026 At the reset edge: pending cleared, state set to IDLE, counter=0, StallCount=FlushCount=0; reset mid-operation aborts the multi-cycle op with no MulDone pulse.

Structure
REQ-027 A shared package hazard_pkg SHALL hold the forward-select encodings (FWD_RF, FWD_WB, FWD_MEM) and the multi-cycle unit state enumeration.
REQ-028 One sub-module sat_counter (parameter CNT_W; ports clk, reset, inc, count) SHALL be instantiated for each counter.

Verification
REQ-029 RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10; with RegWriteM=0 -> ForwardAE=01; with RA1E=15 -> ForwardAE=00.
REQ-030 MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for one cycle, StallCount increments by 1.
REQ-031 MUL_LAT=3, MulStartE at cycle 10 with WA3E=7, RA1D=7 held -> MulDone only at cycle 13, MulDst=7, StallD=1 in cycles 11..13, StallD=0 in cycle 14.
REQ-032 MulOpD=1 while MulBusy -> StallD=1 until MulBusy falls; a second MulStartE during BUSY produces no extra MulDone.
REQ-033 PCSrcD=1 -> StallF=1, FlushD=1, StallD=0; BranchTakenE=1 -> FlushD=FlushE=1, FlushCount increments.
REQ-034 reset asserted at cycle t+1 after MulStartE -> MulBusy=0, no MulDone, pending cleared, both counters read 0 the following cycle.
